// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack.
// Drives the instruction memory address; targets come from decode.
module pc_call_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             push;
  logic             is_full;
  logic             is_empty;

  assign pc_inc   = out_q + WIDTH'(1);
  assign push_idx = depth_q[AW-1:0];
  // At depth==DEPTH the low bits wrap to 0, so -1 lands on DEPTH-1.
  assign top_idx  = depth_q[AW-1:0] - AW'(1);
  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);

  always_comb begin
    out_d   = out_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (ret) begin
      if (is_empty) begin
        err_d = 1'b1;
      end else begin
        out_d   = stack_q[top_idx];
        depth_d = depth_q - DW'(1);
      end
    end else if (call) begin
      if (is_full) begin
        err_d = 1'b1;
      end else begin
        push    = 1'b1;
        out_d   = in;
        depth_d = depth_q + DW'(1);
      end
    end else if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; entries above depth are never read.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign out   = out_q;
  assign depth = depth_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign err   = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack.
// Expected state is queued at drive time and checked after the edge.
module tb_pc_call_stack;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in = '0;
  logic         load = 1'b0;
  logic         inc = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [W-1:0] out;
  logic [3:0]   depth;
  logic         full;
  logic         empty;
  logic         err;

  pc_call_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in(in),
    .load(load), .inc(inc), .call(call), .ret(ret),
    .out(out), .depth(depth), .full(full),
    .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    int           dep;
    logic         er;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;

  logic [W-1:0] m_pc;
  int           m_dep;
  logic         m_err;
  logic [W-1:0] m_stk [D];

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_dep = 0;
    m_err = 1'b0;
  endtask

  task automatic step(input logic r, input logic c,
                      input logic l, input logic i,
                      input logic [W-1:0] t);
    exp_t e;
    @(negedge clk);
    ret = r; call = c; load = l; inc = i; in = t;
    if (r) begin
      if (m_dep == 0) m_err = 1'b1;
      else begin
        m_dep--;
        m_pc = m_stk[m_dep];
      end
    end else if (c) begin
      if (m_dep == D) m_err = 1'b1;
      else begin
        m_stk[m_dep] = m_pc + 16'd1;
        m_dep++;
        m_pc = t;
      end
    end else if (l) m_pc = t;
    else if (i) m_pc = m_pc + 16'd1;
    e.pc = m_pc; e.dep = m_dep; e.er = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out", int'(out), int'(e.pc));
    chk("depth", int'(depth), e.dep);
    chk("err", int'(err), int'(e.er));
    chk("full", int'(full), int'(e.dep == D));
    chk("empty", int'(empty), int'(e.dep == 0));
    ret = 0; call = 0; load = 0; inc = 0;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk({tag, "_out"}, int'(out), 0);
    chk({tag, "_depth"}, int'(depth), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_err"}, int'(err), 0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12 reset = 1'b0;
    pulse_reset("rst0");

    step(0, 0, 1, 0, 16'hFFFE);
    chk("ld_fffe", int'(out), 16'hFFFE);
    step(0, 0, 0, 1, 16'h0);
    chk("inc_ffff", int'(out), 16'hFFFF);
    step(0, 0, 0, 1, 16'h0);
    chk("inc_wrap", int'(out), 16'h0000);
    step(0, 0, 0, 1, 16'h0);
    chk("inc_0001", int'(out), 16'h0001);

    step(0, 0, 1, 0, 16'h0010);
    step(0, 0, 1, 1, 16'h0200);
    chk("ld_over_inc", int'(out), 16'h0200);
    step(0, 0, 0, 1, 16'h0);
    chk("inc_0201", int'(out), 16'h0201);
    step(0, 1, 1, 1, 16'h0300);
    chk("call_wins", int'(out), 16'h0300);
    chk("call_dep", int'(depth), 1);
    step(1, 0, 0, 0, 16'h0);
    chk("top_0202", int'(out), 16'h0202);

    step(0, 0, 1, 0, 16'h0100);
    step(0, 1, 0, 0, 16'h0400);
    chk("nest1", int'(out), 16'h0400);
    step(0, 1, 0, 0, 16'h0500);
    chk("nest2", int'(out), 16'h0500);
    step(1, 0, 0, 0, 16'h0);
    chk("nest3", int'(out), 16'h0401);
    step(1, 0, 0, 0, 16'h0);
    chk("nest4", int'(out), 16'h0101);
    chk("nest_err", int'(err), 0);

    step(0, 0, 1, 0, 16'h1000);
    for (int k = 0; k < D; k++)
      step(0, 1, 0, 0, 16'h2000 + 16'(k * 16));
    chk("ovf_full", int'(full), 1);
    chk("ovf_err0", int'(err), 0);
    step(0, 1, 0, 0, 16'hABCD);
    chk("ovf_out", int'(out), 16'h2070);
    chk("ovf_dep", int'(depth), 8);
    chk("ovf_err1", int'(err), 1);
    for (int k = 0; k < D; k++) step(1, 0, 0, 0, 16'h0);
    chk("unwind", int'(out), 16'h1001);

    pulse_reset("rst1");
    step(0, 0, 1, 0, 16'h0042);
    step(1, 0, 0, 0, 16'h0);
    chk("udf_out", int'(out), 16'h0042);
    chk("udf_err", int'(err), 1);

    pulse_reset("rst2");
    step(0, 0, 1, 0, 16'h0700);
    step(0, 1, 0, 0, 16'h0800);
    step(1, 1, 0, 0, 16'h0900);
    chk("cr_out", int'(out), 16'h0701);
    chk("cr_dep", int'(depth), 0);
    chk("cr_err", int'(err), 0);

    step(1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 3; k++)
      step(0, 1, 0, 0, 16'h3000 + 16'(k));
    @(negedge clk);
    call = 1'b1; in = 16'h5555;
    pulse_reset("rst3");
    call = 1'b0;
    @(posedge clk); #1;
    chk("abort_dep", int'(depth), 0);
    step(1, 0, 0, 0, 16'h0);
    chk("post_udf", int'(err), 1);

    pulse_reset("rst4");
    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Program counter with an integrated hardware return-address stack, for the memories and program-counter stage. It sits directly downstream of the 1-bit load register and the word registers built from it. It holds the current instruction address and advances it (increment, jump, call, return) on each clock. Its `out` port drives the instruction memory address; its `in` port takes jump/call targets from the decode stage.

## Interface
- `WIDTH`, 16, address width in bits
- `DEPTH`, 8, return-stack entries (power of 2, ≥2)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in`  in  WIDTH  jump/call target address
- `load`  in  1  jump: `out <= in`
- `inc`  in  1  advance: `out <= out + 1`
- `call`  in  1  push `out + 1`, then `out <= in`
- `ret`  in  1  pop: `out <= top of stack`
- `out`  out  WIDTH  current program counter (registered)
- `depth`  out  $clog2(DEPTH)+1  number of valid stack entries
- `full`  out  1  `depth == DEPTH`
- `empty`  out  1  `depth == 0`
- `err`  out  1  sticky overflow/underflow flag

## Operation
- Command priority per edge, with exactly one action taken:
  - `ret`
  - `call`
  - `load`
  - `inc`
  - hold (`out` unchanged)
- **ret**, stack not empty: `out <= stack[depth-1]`, `depth <= depth-1`.
- **ret**, stack empty (underflow): `out` holds, `depth` stays 0, `err <= 1`.
- **call**, stack not full: `stack[depth] <= out+1` (mod 2^WIDTH), `depth <= depth+1`, `out <= in`.
- **call**, stack full (overflow): no push, `out` holds, `depth` unchanged, `err <= 1`.
- **load**: `out <= in`; stack untouched.
- **inc**: `out <= out+1`, wrapping 2^WIDTH-1 → 0; stack untouched.
- Arithmetic is unsigned and WIDTH bits. Carry out of the increment is discarded, including on the pushed return address.
- `err` is sticky. Only `reset` clears it. Subsequent valid commands still execute normally while `err=1`.
- Stack storage is not reset. Entries at index ≥ `depth` are don't-care and are never visible on `out`.
- `full`/`empty` are combinational decodes of the registered `depth`.

## Timing
- `reset` asserted, asynchronously and regardless of `clk`: `out=0`, `depth=0`, `empty=1`, `full=0`, `err=0`.
- `reset` asserted mid-operation (e.g. while `call` is high) aborts the command. No push completes, and state is as above immediately.
- Release of `reset`: the first rising edge with `reset=0` executes the commands present at that edge.
- Latency: 1 cycle. Commands sampled at edge N are visible on `out`/`depth`/`err` after edge N. Nothing is combinational from inputs to outputs.
- `ret` sees the stack state before the same-edge `call`. Simultaneous `call`+`ret` = `ret` only; `call` is ignored with no push and no error.
- `call` immediately after `ret` (back-to-back edges) reuses the freed slot; `depth` returns to its previous value.
- Push at `depth=DEPTH-1` succeeds and gives `full=1`. The next `call` is overflow.

## Test plan
- Reset/increment wrap: assert reset mid-cycle → `out=0`, `empty=1`, `err=0` without waiting for a clock. Then `load` `in=16'hFFFE`, then `inc` ×3 → `out` = FFFE, FFFF, 0000, 0001.
- Priority: at `out=16'h0010`, drive `load=1,inc=1,in=16'h0200` → `out=16'h0200`. Drive `inc=1` alone → `16'h0201`. Drive all of `call`, `load`, `inc` with `in=16'h0300` → call wins: `out=16'h0300`, `depth=1`, top=`16'h0202`.
- Nested call/return: from `out=16'h0100`, call `16'h0400`, then call `16'h0500`, then `ret`, `ret` → `out` = 0400, 0500, 0401, 0101; `depth` = 1, 2, 1, 0; `err=0`.
- Overflow: DEPTH=8, 8 calls → `full=1`, `depth=8`, `err=0`. 9th call with `in=16'hABCD` → `out` unchanged, `depth=8`, `err=1`. Then 8 `ret` unwind correctly despite `err=1`.
- Underflow and simultaneous commands: on an empty stack, `ret` → `out` holds, `err=1`. After reset, a call then `call=1,ret=1` on the same edge → `ret` only: `depth` 1 → 0, `out` = pushed return address.
- Reset mid-stack: with `depth=3` and `err=1`, pulse `reset` between clock edges → `out=0`, `depth=0`, `err=0` immediately. A following `ret` → underflow, `err=1`.
